// File: rtl/ddu_pkg.sv
// Shared definitions for the debug & display unit.
//  - FSM state encoding
//  - field widths
//  - active-low hex-to-seven-segment table, bit order {g,f,e,d,c,b,a}
package ddu_pkg;

    localparam int unsigned DEB_W  = 20;
    localparam int unsigned SCAN_W = 17;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned DIG_W  = 3;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned LED_W  = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CONT      = 2'd1,
        STEP_RUN  = 2'd2,
        STEP_HOLD = 2'd3
    } ddu_state_e;

    // Entry [n] is the active-low pattern for hex digit n (listed F down to 0).
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/ddu_debounce.sv
// Two-flop synchronizer followed by a stability-counter debouncer.
//  clk, rst : clock, asynchronous active-high reset
//  raw      : asynchronous switch/button input
//  level    : debounced level; changes after DEB_CYCLES consecutive differing samples
//  rise     : one-cycle pulse, aligned with level going 0->1
module ddu_debounce
    import ddu_pkg::*;
#(
    parameter logic [DEB_W-1:0] DEB_CYCLES = 20'd1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic             sync_q1;
    logic             sync_q2;
    logic [DEB_W-1:0] cnt;

    // Synchronize, then only accept a new value once it has held steadily.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
            rise    <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == DEB_CYCLES - DEB_W'(1)) begin
                level <= sync_q2;
                rise  <= sync_q2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/ddu_debug_unit.sv
// Debug & display unit sitting in front of the multicycle CPU.
// Provides continuous-run and single-step control, a debug address
// counter and an 8-digit multiplexed seven-segment display.
//  clk, rst  : clock, asynchronous active-high reset
//  cont      : switch, 1 = continuous run
//  step      : button, execute one instruction
//  mem       : switch, 1 = show mem_data, 0 = show reg_data
//  inc, dec  : buttons, addr +1 / -1 (wrapping)
//  pc        : CPU New_PC
//  mem_data  : CPU memory word at addr
//  reg_data  : CPU register addr[4:0]
//  run       : high only in continuous mode
//  enable    : CPU may advance
//  addr      : inspection address
//  led       : {step_err, 7'b0, addr}
//  an, seg   : active-low digit anodes and segments {g..a}
module ddu_debug_unit
    import ddu_pkg::*;
#(
    parameter logic [DEB_W-1:0]  DEB_CYCLES = 20'd1_000_000,
    parameter logic [SCAN_W-1:0] SCAN_DIV   = 17'd100_000,
    parameter logic [STEP_W-1:0] STEP_MAX   = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cont,
    input  logic              step,
    input  logic              mem,
    input  logic              inc,
    input  logic              dec,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] reg_data,
    output logic              run,
    output logic              enable,
    output logic [ADDR_W-1:0] addr,
    output logic [LED_W-1:0]  led,
    output logic [DIGITS-1:0] an,
    output logic [SEG_W-1:0]  seg
);

    // ---------------------------------------------------------------
    // Input conditioning
    // ---------------------------------------------------------------
    logic cont_lvl, cont_rise;
    logic step_lvl, step_rise;
    logic mem_lvl,  mem_rise;
    logic inc_lvl,  inc_rise;
    logic dec_lvl,  dec_rise;

    ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_cont (
        .clk(clk), .rst(rst), .raw(cont), .level(cont_lvl), .rise(cont_rise)
    );
    ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk(clk), .rst(rst), .raw(step), .level(step_lvl), .rise(step_rise)
    );
    ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mem (
        .clk(clk), .rst(rst), .raw(mem), .level(mem_lvl), .rise(mem_rise)
    );
    ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .rst(rst), .raw(inc), .level(inc_lvl), .rise(inc_rise)
    );
    ddu_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dec (
        .clk(clk), .rst(rst), .raw(dec), .level(dec_lvl), .rise(dec_rise)
    );

    // Debouncer outputs this block has no use for.
    logic unused_deb;
    assign unused_deb = ^{cont_rise, mem_rise, inc_lvl, dec_lvl};

    // ---------------------------------------------------------------
    // Run / step FSM
    // ---------------------------------------------------------------
    ddu_state_e        state, state_nx;
    logic [DATA_W-1:0] pc_snap, pc_snap_nx;
    logic [STEP_W-1:0] step_cnt, step_cnt_nx;
    logic              step_err, step_err_nx;
    logic              run_nx, enable_nx;

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc_snap  <= '0;
            step_cnt <= '0;
            step_err <= 1'b0;
            run      <= 1'b0;
            enable   <= 1'b0;
        end else begin
            state    <= state_nx;
            pc_snap  <= pc_snap_nx;
            step_cnt <= step_cnt_nx;
            step_err <= step_err_nx;
            run      <= run_nx;
            enable   <= enable_nx;
        end
    end

    // Next state; outputs follow the state being entered.
    always_comb begin
        state_nx    = state;
        pc_snap_nx  = pc_snap;
        step_cnt_nx = step_cnt;
        step_err_nx = step_err;

        case (state)
            IDLE: begin
                if (cont_lvl) begin
                    state_nx = CONT;
                end else if (step_rise) begin
                    state_nx    = STEP_RUN;
                    pc_snap_nx  = pc;
                    step_err_nx = 1'b0;
                    step_cnt_nx = '0;
                end
            end
            CONT: begin
                if (!cont_lvl) begin
                    state_nx = IDLE;
                end
            end
            STEP_RUN: begin
                step_cnt_nx = step_cnt + STEP_W'(1);
                if (cont_lvl) begin
                    state_nx = CONT;
                end else if (pc != pc_snap) begin
                    state_nx = STEP_HOLD;
                end else if (step_cnt == STEP_MAX - STEP_W'(1)) begin
                    // PC never moved: give up and flag it.
                    step_err_nx = 1'b1;
                    state_nx    = STEP_HOLD;
                end
            end
            STEP_HOLD: begin
                // Held button must be released before another step is taken.
                if (!step_lvl) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        run_nx    = (state_nx == CONT);
        enable_nx = (state_nx == CONT) || (state_nx == STEP_RUN);
    end

    // ---------------------------------------------------------------
    // Inspection address
    // ---------------------------------------------------------------
    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (inc_rise && !dec_rise) begin
            addr <= addr + ADDR_W'(1);
        end else if (dec_rise && !inc_rise) begin
            addr <= addr - ADDR_W'(1);
        end
    end

    assign led = {step_err, 7'b0, addr};

    // ---------------------------------------------------------------
    // Seven-segment scan
    // ---------------------------------------------------------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [DIG_W-1:0]  digit;
    logic [DATA_W-1:0] shown;
    logic [3:0]        nibble;

    assign shown  = mem_lvl ? mem_data : reg_data;
    assign nibble = shown[{digit, 2'b00} +: 4];

    // Digit advances each time the prescaler wraps; an/seg describe the current digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= '0;
            an       <= 8'hFF;
            seg      <= 7'h7F;
        end else begin
            if (scan_cnt == SCAN_DIV - SCAN_W'(1)) begin
                scan_cnt <= '0;
                digit    <= digit + DIG_W'(1);
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end
            an  <= ~(DIGITS'(1) << digit);
            seg <= hex_to_seg(nibble);
        end
    end

endmodule

// File: tb/tb_ddu_debug_unit.sv
// Scoreboard bench for ddu_debug_unit with shortened timing parameters.
module tb_ddu_debug_unit;

    localparam int SEL_RUN   = 0;
    localparam int SEL_EN    = 1;
    localparam int SEL_ADDR  = 2;
    localparam int SEL_LED   = 3;
    localparam int SEL_LED15 = 4;
    localparam int SEL_AN    = 5;
    localparam int SEL_SEG   = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cont = 1'b0, step = 1'b0, mem = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [31:0] pc = '0, mem_data = '0, reg_data = '0;
    logic        run, enable;
    logic [7:0]  addr;
    logic [15:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;

    ddu_debug_unit #(
        .DEB_CYCLES(20'd4),
        .SCAN_DIV  (17'd4),
        .STEP_MAX  (8'd8)
    ) dut (
        .clk(clk), .rst(rst), .cont(cont), .step(step), .mem(mem),
        .inc(inc), .dec(dec), .pc(pc), .mem_data(mem_data), .reg_data(reg_data),
        .run(run), .enable(enable), .addr(addr), .led(led), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } snap_t;

    snap_t       q_snap[$];
    int          q_burst[$];   // expected enable burst lengths, -1 = length not checked
    logic [7:0]  q_addr[$];    // expected successive addr values
    int          total = 0;
    int          bad   = 0;
    bit          mon_en = 1'b0;
    bit          done   = 1'b0;

    function automatic logic [31:0] cur(input int sel);
        case (sel)
            SEL_RUN:   return 32'(run);
            SEL_EN:    return 32'(enable);
            SEL_ADDR:  return 32'(addr);
            SEL_LED:   return 32'(led);
            SEL_LED15: return 32'(led[15]);
            SEL_AN:    return 32'(an);
            SEL_SEG:   return 32'(seg);
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_now(input string name, input int sel, input logic [31:0] exp);
        snap_t s;
        s.name = name;
        s.sel  = sel;
        s.exp  = exp;
        q_snap.push_back(s);
    endtask

    // Bounded wait; an expired budget becomes a comparison that will fail.
    task automatic wait_for(input string name, input int sel, input logic [31:0] val, input int budget);
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (cur(sel) == val) return;
        end
        expect_now({"timeout_", name}, sel, val);
    endtask

    // Monitor: compares queued expectations against what the DUT presents.
    initial begin
        snap_t      s;
        int         burst_len;
        int         cycles;
        int         exp_len;
        logic [7:0] prev_addr;
        burst_len = 0;
        cycles    = 0;
        prev_addr = 8'h00;
        forever begin
            @(negedge clk);
            cycles++;
            if (cycles > 20000) begin
                $display("FAIL watchdog: got %0d cycles expected completion", cycles);
                total++;
                bad++;
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
            if (mon_en) begin
                while (q_snap.size() > 0) begin
                    s = q_snap.pop_front();
                    chk(s.name, cur(s.sel), s.exp);
                end
                if (enable === 1'b1) begin
                    burst_len++;
                end else if (burst_len > 0) begin
                    if (q_burst.size() == 0) begin
                        chk("unexpected_enable_burst", 32'(burst_len), 32'd0);
                    end else begin
                        exp_len = q_burst.pop_front();
                        if (exp_len >= 0) chk("enable_burst_len", 32'(burst_len), 32'(exp_len));
                    end
                    burst_len = 0;
                end
                if (addr !== prev_addr) begin
                    if (q_addr.size() == 0) chk("unexpected_addr_change", 32'(addr), 32'(prev_addr));
                    else                    chk("addr_update", 32'(addr), 32'(q_addr.pop_front()));
                    prev_addr = addr;
                end
                if (done) begin
                    chk("leftover_burst_expectations", 32'(q_burst.size()), 32'd0);
                    chk("leftover_addr_expectations", 32'(q_addr.size()), 32'd0);
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $finish;
                end
            end
        end
    end

    // Stimulus
    initial begin
        // Reset values
        tick(2);
        mon_en = 1'b1;
        expect_now("rst_run", SEL_RUN, 32'h0);
        expect_now("rst_enable", SEL_EN, 32'h0);
        expect_now("rst_addr", SEL_ADDR, 32'h0);
        expect_now("rst_led", SEL_LED, 32'h0);
        expect_now("rst_an", SEL_AN, 32'hFF);
        expect_now("rst_seg", SEL_SEG, 32'h7F);
        tick(1);
        rst = 1'b0;
        tick(2);

        // 1: reset in the middle of a step
        q_burst.push_back(-1);
        step = 1'b1;
        wait_for("t1_enable", SEL_EN, 32'h1, 20);
        tick(2);
        rst  = 1'b1;
        step = 1'b0;
        #1;
        expect_now("t1_run", SEL_RUN, 32'h0);
        expect_now("t1_enable", SEL_EN, 32'h0);
        expect_now("t1_addr", SEL_ADDR, 32'h0);
        expect_now("t1_an", SEL_AN, 32'hFF);
        expect_now("t1_seg", SEL_SEG, 32'h7F);
        tick(1);
        rst = 1'b0;
        tick(12);
        expect_now("t1_idle_enable", SEL_EN, 32'h0);
        expect_now("t1_idle_run", SEL_RUN, 32'h0);
        tick(2);

        // 2: step, pc advances 0->4 after three enable cycles
        pc = 32'h0;
        q_burst.push_back(4);
        fork
            begin
                step = 1'b1;
                tick(10);
                step = 1'b0;
            end
            begin
                wait_for("t2_enable", SEL_EN, 32'h1, 20);
                tick(3);
                pc = 32'h4;
            end
        join
        tick(2);
        expect_now("t2_hold_enable", SEL_EN, 32'h0);
        tick(15);
        expect_now("t2_no_second_step", SEL_EN, 32'h0);
        expect_now("t2_no_err", SEL_LED15, 32'h0);

        // 3: step with pc frozen -> timeout, error flag, cleared by next step
        pc = 32'h8;
        tick(2);
        q_burst.push_back(8);
        step = 1'b1;
        wait_for("t3_enable", SEL_EN, 32'h1, 20);
        wait_for("t3_abort", SEL_EN, 32'h0, 20);
        expect_now("t3_err_set", SEL_LED15, 32'h1);
        tick(3);
        step = 1'b0;
        tick(12);
        q_burst.push_back(8);
        step = 1'b1;
        wait_for("t3_enable2", SEL_EN, 32'h1, 20);
        expect_now("t3_err_cleared", SEL_LED15, 32'h0);
        wait_for("t3_abort2", SEL_EN, 32'h0, 20);
        expect_now("t3_err_set2", SEL_LED15, 32'h1);
        step = 1'b0;
        tick(12);

        // 4: address counter with wrap and cancellation
        for (int i = 1; i <= 3; i++) begin
            q_addr.push_back(8'(i));
            inc = 1'b1;
            tick(8);
            inc = 1'b0;
            tick(8);
        end
        q_addr.push_back(8'h02);
        q_addr.push_back(8'h01);
        q_addr.push_back(8'h00);
        q_addr.push_back(8'hFF);
        for (int i = 0; i < 4; i++) begin
            dec = 1'b1;
            tick(8);
            dec = 1'b0;
            tick(8);
        end
        expect_now("t4_addr_wrap", SEL_ADDR, 32'hFF);
        inc = 1'b1;
        dec = 1'b1;
        tick(8);
        inc = 1'b0;
        dec = 1'b0;
        tick(8);
        expect_now("t4_addr_cancel", SEL_ADDR, 32'hFF);
        expect_now("t4_led", SEL_LED, 32'h80FF);

        // 5: glitch rejected; cont during STEP_RUN takes over
        step = 1'b1;
        tick(2);
        step = 1'b0;
        tick(12);
        expect_now("t5_glitch_enable", SEL_EN, 32'h0);
        expect_now("t5_glitch_err_kept", SEL_LED15, 32'h1);
        q_burst.push_back(-1);
        step = 1'b1;
        wait_for("t5_enable", SEL_EN, 32'h1, 20);
        cont = 1'b1;
        wait_for("t5_run", SEL_RUN, 32'h1, 20);
        expect_now("t5_cont_run", SEL_RUN, 32'h1);
        expect_now("t5_cont_enable", SEL_EN, 32'h1);
        expect_now("t5_err_cleared", SEL_LED15, 32'h0);
        step = 1'b0;
        tick(10);
        expect_now("t5_cont_kept", SEL_RUN, 32'h1);
        cont = 1'b0;
        wait_for("t5_run_off", SEL_RUN, 32'h0, 20);
        tick(1);
        expect_now("t5_idle_enable", SEL_EN, 32'h0);

        // 6: display scan
        mem_data = 32'h1234_ABCD;
        reg_data = 32'h0000_0005;
        mem      = 1'b1;
        tick(12);
        wait_for("t6_digit0", SEL_AN, 32'hFE, 40);
        expect_now("t6_mem_digit0_seg", SEL_SEG, 32'h21);
        wait_for("t6_digit7", SEL_AN, 32'h7F, 40);
        expect_now("t6_mem_digit7_seg", SEL_SEG, 32'h79);
        mem = 1'b0;
        tick(12);
        wait_for("t6_reg_digit0", SEL_AN, 32'hFE, 40);
        expect_now("t6_reg_digit0_seg", SEL_SEG, 32'h12);
        wait_for("t6_reg_digit1", SEL_AN, 32'hFD, 40);
        expect_now("t6_reg_digit1_seg", SEL_SEG, 32'h40);
        tick(1);
        done = 1'b1;
    end

endmodule
